// File: rtl/enemy_formation_ctrl.sv
// Purpose: marches the enemy formation across the playfield, one step per move_tick.
// Latency: one cycle; a tick or start sampled at edge N is visible from cycle N+1.
// Backpressure: none; ticks are dropped when idle/landed or while freeze is high.
//
// Ports:
//   clk, reset (async active-low)
//   move_tick, start, freeze  : control inputs
//   pos_x, pos_y, dir         : formation position and marching direction
//   velocity                  : speed fed back to the movement counter
//   moved, landed             : step pulse and landed flag
module enemy_formation_ctrl #(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 560,
  parameter int Y_START = 40,
  parameter int Y_MAX   = 400,
  parameter int STEP_X  = 8,
  parameter int STEP_Y  = 16,
  parameter int V_INIT  = 2,
  parameter int V_STEP  = 1,
  parameter int V_MAX   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        start,
  input  logic        freeze,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        dir,
  output logic [31:0] velocity,
  output logic        moved,
  output logic        landed
);

  typedef enum logic [1:0] {IDLE, MARCH, LANDED} state_t;

  state_t      state, state_nxt;
  logic [9:0]  pos_x_nxt, pos_y_nxt;
  logic        dir_nxt, moved_nxt, landed_nxt;
  logic [31:0] velocity_nxt;

  // Boundary sums are one bit wider than the position so they cannot wrap.
  logic [10:0] x_sum, y_sum;
  logic [32:0] vel_sum;
  logic [31:0] vel_clamped;

  assign x_sum       = {1'b0, pos_x} + 11'(STEP_X);
  assign y_sum       = {1'b0, pos_y} + 11'(STEP_Y);
  assign vel_sum     = {1'b0, velocity} + 33'(V_STEP);
  assign vel_clamped = (vel_sum > 33'(V_MAX)) ? 32'(V_MAX) : vel_sum[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pos_x    <= 10'(X_MIN);
      pos_y    <= 10'(Y_START);
      dir      <= 1'b1;
      velocity <= 32'(V_INIT);
      moved    <= 1'b0;
      landed   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      dir      <= dir_nxt;
      velocity <= velocity_nxt;
      moved    <= moved_nxt;
      landed   <= landed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    dir_nxt      = dir;
    velocity_nxt = velocity;
    moved_nxt    = 1'b0;
    landed_nxt   = landed;

    case (state)
      // Start beats a coincident tick: the reload happens and the tick is dropped.
      IDLE, LANDED: begin
        if (start) begin
          state_nxt    = MARCH;
          pos_x_nxt    = 10'(X_MIN);
          pos_y_nxt    = 10'(Y_START);
          dir_nxt      = 1'b1;
          velocity_nxt = 32'(V_INIT);
          landed_nxt   = 1'b0;
        end
      end
      MARCH: begin
        if (move_tick && !freeze) begin
          moved_nxt = 1'b1;
          if (dir && (x_sum <= 11'(X_MAX))) begin
            pos_x_nxt = x_sum[9:0];
          end else if (!dir && ({1'b0, pos_x} >= 11'(X_MIN + STEP_X))) begin
            pos_x_nxt = pos_x - 10'(STEP_X);
          end else begin
            // Edge reached: drop a row, turn around and speed up.
            dir_nxt      = ~dir;
            velocity_nxt = vel_clamped;
            if (y_sum >= 11'(Y_MAX)) begin
              pos_y_nxt  = 10'(Y_MAX);
              landed_nxt = 1'b1;
              state_nxt  = LANDED;
            end else begin
              pos_y_nxt = y_sum[9:0];
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
module tb_enemy_formation_ctrl;

  typedef struct {
    int xmin, xmax, ystart, ymax, sx, sy, vinit, vstep, vmax;
  } prm_t;

  // Behavioural view: "running" means marching; not running and not landed is idle.
  typedef struct {
    bit     running;
    bit     land;
    int     x, y;
    bit     dir;
    longint vel;
    bit     moved;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic move_tick = 1'b0;
  logic start = 1'b0;
  logic freeze = 1'b0;

  logic [9:0]  px [3];
  logic [9:0]  py [3];
  logic        dr [3];
  logic [31:0] vl [3];
  logic        mv [3];
  logic        ld [3];

  prm_t p [3];
  mdl_t m [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // u0: default geometry; u1: narrow field; u2: landing and velocity clamp.
  enemy_formation_ctrl u0 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .start(start), .freeze(freeze),
    .pos_x(px[0]), .pos_y(py[0]), .dir(dr[0]), .velocity(vl[0]), .moved(mv[0]), .landed(ld[0])
  );

  enemy_formation_ctrl #(.X_MAX(24)) u1 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .start(start), .freeze(freeze),
    .pos_x(px[1]), .pos_y(py[1]), .dir(dr[1]), .velocity(vl[1]), .moved(mv[1]), .landed(ld[1])
  );

  enemy_formation_ctrl #(.X_MAX(0), .Y_START(376), .Y_MAX(400), .V_INIT(31), .V_MAX(32)) u2 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .start(start), .freeze(freeze),
    .pos_x(px[2]), .pos_y(py[2]), .dir(dr[2]), .velocity(vl[2]), .moved(mv[2]), .landed(ld[2])
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input prm_t q);
    mdl_t r;
    r.running = 1'b0;
    r.land    = 1'b0;
    r.x       = q.xmin;
    r.y       = q.ystart;
    r.dir     = 1'b1;
    r.vel     = q.vinit;
    r.moved   = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t c, input prm_t q, input bit s, input bit t, input bit f);
    mdl_t n = c;
    n.moved = 1'b0;
    if (!c.running) begin
      if (s) begin
        n = mdl_reset(q);
        n.running = 1'b1;
      end
    end else if (t && !f) begin
      n.moved = 1'b1;
      if (c.dir && (c.x + q.sx <= q.xmax))
        n.x = c.x + q.sx;
      else if (!c.dir && (c.x >= q.xmin + q.sx))
        n.x = c.x - q.sx;
      else begin
        n.dir = !c.dir;
        n.vel = (c.vel + q.vstep > q.vmax) ? q.vmax : c.vel + q.vstep;
        if (c.y + q.sy >= q.ymax) begin
          n.y       = q.ymax;
          n.land    = 1'b1;
          n.running = 1'b0;
        end else
          n.y = c.y + q.sy;
      end
    end
    return n;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_pos_x", i), px[i], m[i].x);
      chk($sformatf("u%0d_pos_y", i), py[i], m[i].y);
      chk($sformatf("u%0d_dir", i), dr[i], m[i].dir);
      chk($sformatf("u%0d_velocity", i), vl[i], m[i].vel);
      chk($sformatf("u%0d_moved", i), mv[i], m[i].moved);
      chk($sformatf("u%0d_landed", i), ld[i], m[i].land);
    end
  endtask

  // Called at a negedge; drives inputs, lets one edge pass, checks at the next negedge.
  task automatic cycle(input bit s, input bit t, input bit f);
    start     = s;
    move_tick = t;
    freeze    = f;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mdl_step(m[i], p[i], s, t, f);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    start     = 1'b0;
    move_tick = 1'b0;
    freeze    = 1'b0;
    reset     = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset(p[i]);
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int exp_r[4];
    int exp_l[3];
    int nmoved;
    int r;

    p[0] = '{xmin:0, xmax:560, ystart:40,  ymax:400, sx:8, sy:16, vinit:2,  vstep:1, vmax:32};
    p[1] = '{xmin:0, xmax:24,  ystart:40,  ymax:400, sx:8, sy:16, vinit:2,  vstep:1, vmax:32};
    p[2] = '{xmin:0, xmax:0,   ystart:376, ymax:400, sx:8, sy:16, vinit:31, vstep:1, vmax:32};
    for (int i = 0; i < 3; i++) m[i] = mdl_reset(p[i]);

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Run a little, then reset mid-run.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    start = 1'b0; move_tick = 1'b0; freeze = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_pos_x", px[0], 0);
    chk("rst_pos_y", py[0], 40);
    chk("rst_dir", dr[0], 1);
    chk("rst_velocity", vl[0], 2);
    chk("rst_landed", ld[0], 0);
    for (int i = 0; i < 3; i++) m[i] = mdl_reset(p[i]);
    @(negedge clk);
    reset = 1'b1;

    // Idle ignores ticks.
    repeat (5) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("idle_pos_x", px[0], 0);
      chk("idle_moved", mv[0], 0);
    end

    // Right march to the edge on the narrow field; u2 lands meanwhile.
    cycle(1'b1, 1'b0, 1'b0);
    exp_r  = '{8, 16, 24, 24};
    nmoved = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("right_pos_x", px[1], exp_r[k]);
      nmoved += int'(mv[1]);
      if (k == 0) begin
        chk("land_tick1_y", py[2], 392);
        chk("land_tick1_landed", ld[2], 0);
        chk("clamp_tick1_vel", vl[2], 32);
      end
      if (k == 1) begin
        chk("land_tick2_y", py[2], 400);
        chk("land_tick2_landed", ld[2], 1);
      end
      cycle(1'b0, 1'b0, 1'b0);
      nmoved += int'(mv[1]);
    end
    chk("right_edge_y", py[1], 56);
    chk("right_edge_dir", dr[1], 0);
    chk("right_edge_vel", vl[1], 3);
    chk("right_moved_count", nmoved, 4);

    // Left march to the edge.
    exp_l = '{16, 8, 0};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("left_pos_x", px[1], exp_l[k]);
    end
    cycle(1'b0, 1'b1, 1'b0);
    chk("left_edge_y", py[1], 72);
    chk("left_edge_dir", dr[1], 1);
    chk("left_edge_vel", vl[1], 4);
    chk("landed_hold_y", py[2], 400);
    chk("landed_hold_flag", ld[2], 1);

    // Frozen ticks change nothing.
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("freeze_pos_x", px[1], 0);
      chk("freeze_pos_y", py[1], 72);
      chk("freeze_moved", mv[1], 0);
    end

    // Start during MARCH is ignored; start from LANDED restarts.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("march_pre_start_x", px[1], 16);
    cycle(1'b1, 1'b0, 1'b0);
    chk("march_start_x", px[1], 16);
    chk("march_start_y", py[1], 72);
    chk("restart_y", py[2], 376);
    chk("restart_landed", ld[2], 0);
    chk("restart_vel", vl[2], 31);
    cycle(1'b0, 1'b1, 1'b0);
    chk("clamp_d1_vel", vl[2], 32);
    cycle(1'b0, 1'b1, 1'b0);
    chk("clamp_d2_vel", vl[2], 32);

    // Start with a coincident tick from IDLE: the tick is dropped.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    chk("start_tick_x", px[0], 0);
    chk("start_tick_moved", mv[0], 0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("start_next_x", px[0], 8);

    // Randomized run against the model.
    for (int n = 0; n < 6000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2)
        do_reset();
      else
        cycle(r < 40, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enemy_formation_ctrl.md
# enemy_formation_ctrl

Moves the enemy formation across the playfield, one step per `move_tick` pulse from the enemy movement counter. It marches horizontally and, at each side boundary, steps down, reverses direction and raises `velocity`. `velocity` feeds back to the movement counter, so the formation speeds up after every descent. It flags `landed` when the formation reaches the bottom row.

## Interface
Parameters:
- `X_MIN`, 0: leftmost allowed formation X (left edge)
- `X_MAX`, 560: rightmost allowed formation X (left edge)
- `Y_START`, 40: initial formation Y
- `Y_MAX`, 400: landing Y
- `STEP_X`, 8: horizontal step in pixels
- `STEP_Y`, 16: vertical step in pixels
- `V_INIT`, 2: initial velocity
- `V_STEP`, 1: velocity increment per descent
- `V_MAX`, 32: velocity ceiling

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `move_tick` in 1: single-cycle movement pulse from the movement counter
- `start` in 1: level-sampled start / restart request
- `freeze` in 1: pause; ticks are ignored while high
- `pos_x` out 10: formation X
- `pos_y` out 10: formation Y
- `dir` out 1: 1 = moving right, 0 = moving left
- `velocity` out 32: current speed, sent to the movement counter
- `moved` out 1: one-cycle pulse on each applied step
- `landed` out 1: high in the LANDED state

## Operation
- States are IDLE, MARCH and LANDED. Reset (`reset`=0) forces the following, independent of `clk`:
  - IDLE, `pos_x`=`X_MIN`, `pos_y`=`Y_START`, `dir`=1
  - `velocity`=`V_INIT`, `moved`=0, `landed`=0
- IDLE:
  - `move_tick` is ignored.
  - `start`=1 reloads the initial values (`pos_x`, `pos_y`, `dir`, `velocity`) and enters MARCH.
- MARCH: a step is applied when `move_tick`=1 and `freeze`=0. `start` is ignored.
  - Right (`dir`=1): if `pos_x`+`STEP_X` ≤ `X_MAX`, add `STEP_X` to `pos_x`. Otherwise descend.
  - Left (`dir`=0): if `pos_x` ≥ `X_MIN`+`STEP_X`, subtract `STEP_X` from `pos_x`. Otherwise descend.
  - Descend:
    - `pos_x` is unchanged and `dir` toggles.
    - `velocity` becomes min(`velocity`+`V_STEP`, `V_MAX`).
    - If `pos_y`+`STEP_Y` ≥ `Y_MAX`: `pos_y`=`Y_MAX`, `landed`=1, next state LANDED. Otherwise add `STEP_Y` to `pos_y`.
  - `moved` pulses on every applied step: horizontal, descend or landing.
- LANDED:
  - All outputs hold and `landed`=1.
  - `start`=1 reloads the initial values, clears `landed` and enters MARCH.
- Arithmetic:
  - Compute boundary sums at 11 bits so that `pos_x`+`STEP_X` and `pos_y`+`STEP_Y` cannot wrap.
  - Compute the velocity sum at 33 bits before clamping.
- Simultaneous events:
  - `start` together with `move_tick` in IDLE or LANDED: `start` wins and the tick is dropped.
  - `freeze` together with `move_tick`: no step and no `moved` pulse.
- Reset mid-step discards any pending update. There is no partial state.

## Timing
- All outputs are registered.
- A tick sampled at edge N updates `pos_x`, `pos_y`, `dir`, `velocity` and `landed` at edge N, visible in cycle N+1. `moved` is high for exactly cycle N+1.
- `start` sampled at edge N: values are reloaded and the state is MARCH from cycle N+1. A tick at edge N+1 is applied.
- Exactly one step is applied per tick. A `move_tick` held high for k cycles in MARCH applies k steps; upstream guarantees single-cycle pulses.
- A `velocity` change is visible to the movement counter from cycle N+1. That counter recomputes its period on its next clock.

## Test plan
- Reset and idle: assert `reset`=0 mid-run.
  - Required: `pos_x`=0, `pos_y`=40, `dir`=1, `velocity`=2, `landed`=0 immediately.
  - Then, in IDLE, 5 ticks leave `pos_x`=0 and `moved` never pulses.
- Right march and edge (override `X_MAX`=24): `start`, then 4 ticks.
  - Required `pos_x` sequence: 8, 16, 24, 24.
  - The 4th tick leaves `pos_y`=56, `dir`=0, `velocity`=3.
  - `moved` pulses 4 times.
- Left edge: continue with 3 more ticks.
  - Required `pos_x` sequence: 16, 8, 0.
  - A 4th tick leaves `pos_y`=72, `dir`=1, `velocity`=4.
- Landing (`Y_START`=376, `Y_MAX`=400, `X_MAX`=0):
  - Tick 1 gives `pos_y`=392. Tick 2 gives `pos_y`=400, `landed`=1.
  - Further ticks change nothing.
  - `start` then gives `pos_y`=376, `landed`=0 and MARCH.
- Freeze and velocity clamp (`V_INIT`=31, `V_MAX`=32, `X_MAX`=0):
  - Ticks with `freeze`=1 change nothing.
  - With `freeze`=0, two descends give `velocity` 32, then 32.
- Simultaneous events:
  - `start` and `move_tick` in the same cycle from IDLE: `pos_x`=0 after that edge, and the next tick gives `pos_x`=8.
  - `start` during MARCH at `pos_x`=16 is ignored.
